// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD mm:ss.cc chronometer count with run/pause, lap freeze and clear.
// The count advances on rising edges of the 100 Hz divider output while running.
module stopwatch_core #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] cs_t,
  output logic [3:0] cs_u,
  output logic [3:0] s_t,
  output logic [3:0] s_u,
  output logic [3:0] m_t,
  output logic [3:0] m_u,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 6 * DIGIT_W;

  // BCD digits of the highest legal minutes value
  localparam logic [DIGIT_W-1:0] MT_MAX = DIGIT_W'(MIN_MAX / 10);
  localparam logic [DIGIT_W-1:0] MU_MAX = DIGIT_W'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 tick_q, tick_d;
  logic                 ss_q, ss_d;
  logic                 lap_q, lap_d;
  logic                 clr_q, clr_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   snap_q, snap_d;
  logic                 lap_active_q, lap_active_d;
  logic                 ovf_q, ovf_d;
  logic                 running_q, running_d;

  logic                 tick_ev, ss_ev, lap_ev, clr_ev;
  logic                 clr_do;

  logic [DIGIT_W-1:0]   c_cs_u, c_cs_t, c_s_u, c_s_t, c_m_u, c_m_t;
  logic [DIGIT_W-1:0]   n_cs_u, n_cs_t, n_s_u, n_s_t, n_m_u, n_m_t;
  logic [COUNT_W-1:0]   inc_count;
  logic                 inc_wrap;

  // Rising-edge events against the previous sampled level
  assign tick_ev = tick_in    & ~tick_q;
  assign ss_ev   = start_stop & ~ss_q;
  assign lap_ev  = lap        & ~lap_q;
  assign clr_ev  = clear      & ~clr_q;

  // A clear only takes effect outside RUN; when it does it pre-empts the other buttons
  assign clr_do  = clr_ev & (state_q != ST_RUN);

  // Live count digit fields, packed {m_t, m_u, s_t, s_u, cs_t, cs_u}
  assign c_cs_u = count_q[ 3: 0];
  assign c_cs_t = count_q[ 7: 4];
  assign c_s_u  = count_q[11: 8];
  assign c_s_t  = count_q[15:12];
  assign c_m_u  = count_q[19:16];
  assign c_m_t  = count_q[23:20];

  // Live count plus one centisecond, with BCD carries and minutes wrap
  always_comb begin
    n_cs_u   = c_cs_u + 4'd1;
    n_cs_t   = c_cs_t;
    n_s_u    = c_s_u;
    n_s_t    = c_s_t;
    n_m_u    = c_m_u;
    n_m_t    = c_m_t;
    inc_wrap = 1'b0;
    if (c_cs_u == 4'd9) begin
      n_cs_u = 4'd0;
      if (c_cs_t != 4'd9) begin
        n_cs_t = c_cs_t + 4'd1;
      end else begin
        n_cs_t = 4'd0;
        if (c_s_u != 4'd9) begin
          n_s_u = c_s_u + 4'd1;
        end else begin
          n_s_u = 4'd0;
          if (c_s_t != 4'd5) begin
            n_s_t = c_s_t + 4'd1;
          end else begin
            n_s_t = 4'd0;
            if ((c_m_t == MT_MAX) && (c_m_u == MU_MAX)) begin
              n_m_t    = 4'd0;
              n_m_u    = 4'd0;
              inc_wrap = 1'b1;
            end else if (c_m_u == 4'd9) begin
              n_m_u = 4'd0;
              n_m_t = c_m_t + 4'd1;
            end else begin
              n_m_u = c_m_u + 4'd1;
            end
          end
        end
      end
    end
    inc_count = {n_m_t, n_m_u, n_s_t, n_s_u, n_cs_t, n_cs_u};
  end

  // Next state, count, lap snapshot and flags; tick judged on the pre-transition state
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_in;
    ss_d         = start_stop;
    lap_d        = lap;
    clr_d        = clear;
    count_d      = count_q;
    snap_d       = snap_q;
    lap_active_d = lap_active_q;
    ovf_d        = ovf_q;

    if ((state_q == ST_RUN) && tick_ev) begin
      count_d = inc_count;
      if (inc_wrap) begin
        ovf_d = 1'b1;
      end
    end

    if (clr_do) begin
      state_d      = ST_IDLE;
      count_d      = '0;
      snap_d       = '0;
      lap_active_d = 1'b0;
      ovf_d        = 1'b0;
    end else if (ss_ev) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (lap_ev) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (state_q == ST_RUN) begin
        snap_d       = count_q;
        lap_active_d = 1'b1;
      end
    end

    running_d = (state_d == ST_RUN);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= 1'b0;
      ss_q         <= 1'b0;
      lap_q        <= 1'b0;
      clr_q        <= 1'b0;
      count_q      <= '0;
      snap_q       <= '0;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      ss_q         <= ss_d;
      lap_q        <= lap_d;
      clr_q        <= clr_d;
      count_q      <= count_d;
      snap_q       <= snap_d;
      lap_active_q <= lap_active_d;
      ovf_q        <= ovf_d;
      running_q    <= running_d;
    end
  end

  // Display selects the frozen snapshot while a lap is held
  assign {m_t, m_u, s_t, s_u, cs_t, cs_u} = lap_active_q ? snap_q : count_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (MIN_MAX 59 and 1) on shared stimulus,
// checked every cycle against a centisecond-integer reference model.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_in = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;

  logic [3:0] cs_t0, cs_u0, s_t0, s_u0, m_t0, m_u0;
  logic [3:0] cs_t1, cs_u1, s_t1, s_u1, m_t1, m_u1;
  logic       run0, lapa0, ovf0, run1, lapa1, ovf1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.MIN_MAX(59)) dut0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .lap(lap), .clear(clear),
    .cs_t(cs_t0), .cs_u(cs_u0), .s_t(s_t0), .s_u(s_u0), .m_t(m_t0), .m_u(m_u0),
    .running(run0), .lap_active(lapa0), .ovf(ovf0));

  stopwatch_core #(.MIN_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .lap(lap), .clear(clear),
    .cs_t(cs_t1), .cs_u(cs_u1), .s_t(s_t1), .s_u(s_u1), .m_t(m_t1), .m_u(m_u1),
    .running(run1), .lap_active(lapa1), .ovf(ovf1));

  logic [28:0] v0, v1;
  assign v0 = {m_t0, m_u0, s_t0, s_u0, cs_t0, cs_u0, run0, lapa0, ovf0};
  assign v1 = {m_t1, m_u1, s_t1, s_u1, cs_t1, cs_u1, run1, lapa1, ovf1};

  // Reference model: count held as total centiseconds; state 0 idle, 1 run, 2 pause
  int m_cnt [2];
  int m_snap [2];
  int m_st [2];
  bit m_lapa [2];
  bit m_ovf [2];
  int m_max [2] = '{59, 1};
  bit p_tick, p_ss, p_lap, p_clr;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_snap[k] = 0; m_st[k] = 0; m_lapa[k] = 0; m_ovf[k] = 0;
    end
    p_tick = 0; p_ss = 0; p_lap = 0; p_clr = 0;
  endtask

  task automatic model_step();
    bit te, se, le, ce;
    int c0;
    te = tick_in && !p_tick;
    se = start_stop && !p_ss;
    le = lap && !p_lap;
    ce = clear && !p_clr;
    for (int k = 0; k < 2; k++) begin
      c0 = m_cnt[k];
      if (m_st[k] == 1 && te) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == (m_max[k] + 1) * 6000) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1;
        end
      end
      if (ce && m_st[k] != 1) begin
        m_st[k] = 0; m_cnt[k] = 0; m_snap[k] = 0; m_lapa[k] = 0; m_ovf[k] = 0;
      end else if (se) begin
        m_st[k] = (m_st[k] == 1) ? 2 : 1;
      end else if (le) begin
        if (m_lapa[k]) m_lapa[k] = 0;
        else if (m_st[k] == 1) begin
          m_snap[k] = c0;
          m_lapa[k] = 1;
        end
      end
    end
    p_tick = tick_in; p_ss = start_stop; p_lap = lap; p_clr = clear;
  endtask

  function automatic logic [28:0] mk(int m, int s, int cs, bit r, bit la, bit o);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10), r, la, o};
  endfunction

  function automatic logic [28:0] exp_vec(int k);
    int v;
    v = m_lapa[k] ? m_snap[k] : m_cnt[k];
    return mk(v / 6000, (v / 100) % 60, v % 100, m_st[k] == 1, m_lapa[k], m_ovf[k]);
  endfunction

  task automatic chk(string tag, logic [28:0] obs, logic [28:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model0", v0, exp_vec(0));
    chk("model1", v1, exp_vec(1));
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      tick_in = 1'b1; cyc();
      tick_in = 1'b0; cyc();
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc();
    start_stop = 1'b0; cyc();
  endtask

  task automatic pulse_lap();
    lap = 1'b1; cyc();
    lap = 1'b0; cyc();
  endtask

  task automatic pulse_clr();
    clear = 1'b1; cyc();
    clear = 1'b0; cyc();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", v0, 29'd0);
    chk("reset1", v1, 29'd0);
    @(negedge clk);
    rst = 1'b1;

    // Start and count 150 centiseconds
    pulse_ss();
    ticks(150);
    chk("run150_0", v0, mk(0, 1, 50, 1, 0, 0));
    chk("run150_1", v1, mk(0, 1, 50, 1, 0, 0));

    // Lap freeze at 42, count on underneath, release shows 62
    pulse_ss();
    pulse_clr();
    chk("clear_idle", v0, mk(0, 0, 0, 0, 0, 0));
    pulse_ss();
    ticks(42);
    pulse_lap();
    ticks(20);
    chk("lap_frozen", v0, mk(0, 0, 42, 1, 1, 0));
    pulse_lap();
    chk("lap_release", v0, mk(0, 0, 62, 1, 0, 0));

    // Tick coinciding with pause is counted; with resume it is not
    tick_in = 1'b1; start_stop = 1'b1; cyc();
    chk("tick_at_pause", v0, mk(0, 0, 63, 0, 0, 0));
    tick_in = 1'b0; start_stop = 1'b0; cyc();
    tick_in = 1'b1; start_stop = 1'b1; cyc();
    chk("tick_at_resume", v0, mk(0, 0, 63, 1, 0, 0));
    tick_in = 1'b0; start_stop = 1'b0; cyc();
    ticks(1);
    chk("tick_after_resume", v0, mk(0, 0, 64, 1, 0, 0));

    // Clear beats start_stop in PAUSE; clear alone in RUN is ignored
    pulse_ss();
    clear = 1'b1; start_stop = 1'b1; cyc();
    chk("clear_over_ss", v0, mk(0, 0, 0, 0, 0, 0));
    clear = 1'b0; start_stop = 1'b0; cyc();
    pulse_ss();
    ticks(5);
    pulse_clr();
    ticks(3);
    chk("clear_in_run", v0, mk(0, 0, 8, 1, 0, 0));

    // Run to the MIN_MAX=1 wrap point and one past it
    ticks(11991);
    chk("at_max1", v1, mk(1, 59, 99, 1, 0, 0));
    ticks(1);
    chk("wrap1", v1, mk(0, 0, 0, 1, 0, 1));
    chk("nowrap0", v0, mk(2, 0, 0, 1, 0, 0));
    pulse_ss();
    pulse_clr();
    chk("ovf_cleared", v1, mk(0, 0, 0, 0, 0, 0));

    // Asynchronous reset at 00:37.15 with a lap held, start_stop high across it
    pulse_ss();
    ticks(3715);
    pulse_lap();
    chk("pre_reset", v0, mk(0, 37, 15, 1, 1, 0));
    start_stop = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset0", v0, 29'd0);
    chk("async_reset1", v1, 29'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("run_after_reset", v0, mk(0, 0, 0, 1, 0, 0));
    start_stop = 1'b0;
    cyc();

    // Random levels on all inputs; model tracks every cycle
    for (int i = 0; i < 4000; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 7) == 0)  lap = ~lap;
      if ($urandom_range(0, 13) == 0) clear = ~clear;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
